id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection and bubble/flush control.

---
 rtl/id_ex_stage_pkg.sv | 70 +++++++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared decode-bundle types for the ID/EX boundary: opcodes, the EX/MEM/WB control
// bundles, the ID/EX payload struct and their NOP constants.
package id_ex_stage_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_S     = 7'b0100011,
    OP_SB    = 7'b1100011,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111
  } opcode_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_rw_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
  } ex_control_t;

  typedef struct packed {
    mem_rw_t    MemRW;
    logic [2:0] size;
    logic       unsigned_ld;
  } mem_control_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
  } wb_control_t;

  typedef struct packed {
    ex_control_t         ex;
    mem_control_t        mem;
    wb_control_t         wb;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] rs1_data;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [XLEN_DEF-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
  } id_ex_t;

  localparam ex_control_t  NOP_EX_CTRL  = '0;
  localparam mem_control_t NOP_MEM_CTRL = '{MemRW: MEM_NONE, size: 3'd0, unsigned_ld: 1'b0};
  localparam wb_control_t  NOP_WB_CTRL  = '0;
  localparam id_ex_t       NOP_ID_EX    = '0;

  // LUI, AUIPC and JAL carry no rs1 field; only R, S and SB read rs2.
  function automatic logic uses_rs1(input opcode_t op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input opcode_t op);
    return (op == OP_R || op == OP_S || op == OP_SB);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the rd of a load
// currently sitting in EX.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  opcode_t    opcode_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       valid_id,
  input  logic [4:0] rd_ex,
  input  mem_rw_t    mem_rw_ex,
  input  logic       valid_ex,
  output logic       load_use
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign load_in_ex = valid_ex && (mem_rw_ex == MEM_READ) && (rd_ex != 5'd0);
  assign rs1_hit    = uses_rs1(opcode_id) && (rs1_id == rd_ex);
  assign rs2_hit    = uses_rs2(opcode_id) && (rs2_id == rd_ex);
  assign load_use   = load_in_ex && valid_id && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode results, inserts bubbles on redirect or
// load-use, raises the fetch stall and counts load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  opcode_t          opcode_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic [XLEN-1:0]  pc_id,
  input  logic [XLEN-1:0]  rs1_data_id,
  input  logic [XLEN-1:0]  rs2_data_id,
  input  logic [XLEN-1:0]  imm_id,
  input  logic             valid_id,
  input  ex_control_t      ex_ctrl_id,
  input  mem_control_t     mem_ctrl_id,
  input  wb_control_t      wb_ctrl_id,
  input  logic             redirect_ex,
  input  logic             hold,
  output logic             stall_fetch,
  output id_ex_t           ex_q,
  output logic             valid_ex,
  output logic [CNT_W-1:0] load_use_cnt
);

  id_ex_t           ex_q_reg, ex_q_next;
  logic             valid_ex_reg, valid_ex_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             load_use;
  logic             bubble;

  hazard_detect u_hazard_detect (
    .opcode_id (opcode_id),
    .rs1_id    (rs1_id),
    .rs2_id    (rs2_id),
    .valid_id  (valid_id),
    .rd_ex     (ex_q_reg.rd),
    .mem_rw_ex (ex_q_reg.mem.MemRW),
    .valid_ex  (valid_ex_reg),
    .load_use  (load_use)
  );

  // A redirect squashes the ID instruction anyway, so it must not also freeze fetch.
  assign bubble      = redirect_ex || load_use;
  assign stall_fetch = load_use && !hold && !redirect_ex;

  always_comb begin
    ex_q_next     = ex_q_reg;
    valid_ex_next = 1'b0;
    if (bubble) begin
      // Data fields stay stale; rd is cleared so the bubble cannot match a hazard or forward.
      ex_q_next.ex  = NOP_EX_CTRL;
      ex_q_next.mem = NOP_MEM_CTRL;
      ex_q_next.wb  = NOP_WB_CTRL;
      ex_q_next.rd  = 5'd0;
    end else begin
      ex_q_next.pc       = pc_id;
      ex_q_next.rs1_data = rs1_data_id;
      ex_q_next.rs2_data = rs2_data_id;
      ex_q_next.imm      = imm_id;
      ex_q_next.rs1      = rs1_id;
      ex_q_next.rs2      = rs2_id;
      valid_ex_next      = valid_id;
      if (valid_id) begin
        ex_q_next.ex  = ex_ctrl_id;
        ex_q_next.mem = mem_ctrl_id;
        ex_q_next.wb  = wb_ctrl_id;
        ex_q_next.rd  = rd_id;
      end else begin
        ex_q_next.ex  = NOP_EX_CTRL;
        ex_q_next.mem = NOP_MEM_CTRL;
        ex_q_next.wb  = NOP_WB_CTRL;
        ex_q_next.rd  = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q_reg     <= NOP_ID_EX;
      valid_ex_reg <= 1'b0;
      cnt_reg      <= '0;
    end else if (!hold) begin
      ex_q_reg     <= ex_q_next;
      valid_ex_reg <= valid_ex_next;
      if (load_use && !redirect_ex) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign ex_q         = ex_q_reg;
  assign valid_ex     = valid_ex_reg;
  assign load_use_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed pipeline scenarios then random traffic,
// checked against a behavioural model of the ID/EX register (4-bit counter build).
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  opcode_t          opcode_id;
  logic [4:0]       rs1_id, rs2_id, rd_id;
  logic [XLEN-1:0]  pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic             valid_id;
  ex_control_t      ex_ctrl_id;
  mem_control_t     mem_ctrl_id;
  wb_control_t      wb_ctrl_id;
  logic             redirect_ex, hold;
  logic             stall_fetch;
  id_ex_t           ex_q;
  logic             valid_ex;
  logic [CNT_W-1:0] load_use_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
    .imm_id(imm_id), .valid_id(valid_id), .ex_ctrl_id(ex_ctrl_id), .mem_ctrl_id(mem_ctrl_id),
    .wb_ctrl_id(wb_ctrl_id), .redirect_ex(redirect_ex), .hold(hold),
    .stall_fetch(stall_fetch), .ex_q(ex_q), .valid_ex(valid_ex), .load_use_cnt(load_use_cnt)
  );

  typedef struct {
    id_ex_t           q;
    logic             v;
    logic [CNT_W-1:0] cnt;
    bit               known;  // data fields defined (not stale after a bubble)
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input opcode_t op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic bit reads_rs2(input opcode_t op);
    return op inside {OP_R, OP_S, OP_SB};
  endfunction

  // Called just after a negedge with inputs set; checks stall, predicts the next edge.
  task automatic step();
    bit   haz;
    exp_t nx;
    #1;
    haz = model.v && model.q.mem.MemRW == MEM_READ && model.q.rd != 0 && valid_id &&
          ((reads_rs1(opcode_id) && rs1_id == model.q.rd) ||
           (reads_rs2(opcode_id) && rs2_id == model.q.rd));
    if (!rst) chk("stall_fetch", 64'(stall_fetch), 64'(!hold && !redirect_ex && haz));
    nx = model;
    if (rst) begin
      nx.q = NOP_ID_EX; nx.v = 0; nx.cnt = 0; nx.known = 1;
    end else if (hold) begin
      nx = model;
    end else if (redirect_ex || haz) begin
      nx.q.ex = NOP_EX_CTRL; nx.q.mem = NOP_MEM_CTRL; nx.q.wb = NOP_WB_CTRL;
      nx.q.rd = 0; nx.v = 0; nx.known = 0;
      if (!redirect_ex) nx.cnt = model.cnt + 1'b1;
    end else begin
      nx.q.pc = pc_id; nx.q.rs1_data = rs1_data_id; nx.q.rs2_data = rs2_data_id;
      nx.q.imm = imm_id; nx.q.rs1 = rs1_id; nx.q.rs2 = rs2_id;
      nx.q.ex  = valid_id ? ex_ctrl_id  : NOP_EX_CTRL;
      nx.q.mem = valid_id ? mem_ctrl_id : NOP_MEM_CTRL;
      nx.q.wb  = valid_id ? wb_ctrl_id  : NOP_WB_CTRL;
      nx.q.rd  = valid_id ? rd_id : 5'd0;
      nx.v = valid_id; nx.known = 1;
    end
    model = nx;
    sb.push_back(nx);
    @(negedge clk);
  endtask

  task automatic set_instr(input opcode_t op, input int rd, input int rs1, input int rs2,
                           input mem_rw_t mrw);
    logic [6:0] e7;
    logic [2:0] w3;
    e7 = 7'($urandom); w3 = 3'($urandom);
    opcode_id = op; rd_id = 5'(rd); rs1_id = 5'(rs1); rs2_id = 5'(rs2);
    pc_id = $urandom; rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom;
    ex_ctrl_id = e7; wb_ctrl_id = w3;
    mem_ctrl_id = '{MemRW: mrw, size: 3'($urandom), unsigned_ld: 1'($urandom)};
    valid_id = 1; rst = 0; hold = 0; redirect_ex = 0;
  endtask

  // Monitor: the register presents a new payload every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("valid_ex", 64'(valid_ex), 64'(e.v));
        chk("load_use_cnt", 64'(load_use_cnt), 64'(e.cnt));
        chk("ex_bundle", 64'(ex_q.ex), 64'(e.q.ex));
        chk("mem_bundle", 64'(ex_q.mem), 64'(e.q.mem));
        chk("wb_bundle", 64'(ex_q.wb), 64'(e.q.wb));
        chk("rd", 64'(ex_q.rd), 64'(e.q.rd));
        if (e.known) begin
          chk("pc", 64'(ex_q.pc), 64'(e.q.pc));
          chk("rs1_data", 64'(ex_q.rs1_data), 64'(e.q.rs1_data));
          chk("rs2_data", 64'(ex_q.rs2_data), 64'(e.q.rs2_data));
          chk("imm", 64'(ex_q.imm), 64'(e.q.imm));
          chk("rs_idx", {54'd0, ex_q.rs1, ex_q.rs2}, {54'd0, e.q.rs1, e.q.rs2});
        end
      end
    end
  end

  initial begin
    opcode_t ops[9] = '{OP_R, OP_I, OP_LOAD, OP_S, OP_SB, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    @(negedge clk);
    // Reset two cycles, then an idle slot.
    set_instr(OP_I, 0, 0, 0, MEM_NONE); valid_id = 0; rst = 1;
    step(); step();
    rst = 0; step();
    // lw x5 then dependent add: one stall, then the add is captured.
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_R, 6, 5, 2, MEM_NONE); step(); step();
    // lw x0 then add reading x0; lw x5 then lui x5.
    set_instr(OP_LOAD, 0, 1, 0, MEM_READ); step();
    set_instr(OP_R, 6, 0, 2, MEM_NONE); step();
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_LUI, 5, 5, 5, MEM_NONE); step();
    // lw x5 then sw x5 (rs2 hazard); lw x5 then jal.
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_S, 0, 7, 5, MEM_WRITE); step(); step();
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_JAL, 1, 5, 5, MEM_NONE); step();
    // Hazard with redirect, then hazard frozen by hold for three cycles.
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_R, 6, 5, 2, MEM_NONE); redirect_ex = 1; step();
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_R, 6, 5, 2, MEM_NONE); hold = 1; step(); step(); step();
    hold = 0; step(); step();
    // Sixteen load-use bubbles wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      set_instr(OP_LOAD, 3, 1, 0, MEM_READ); step();
      set_instr(OP_I, 4, 3, 0, MEM_NONE); step(); step();
    end
    // Reset asserted while the stall is active.
    set_instr(OP_LOAD, 5, 1, 0, MEM_READ); step();
    set_instr(OP_R, 6, 5, 2, MEM_NONE); rst = 1; step();
    rst = 0; step();
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), mem_rw_t'(2'($urandom_range(0, 2))));
      valid_id    = ($urandom_range(0, 9) != 0);
      hold        = ($urandom_range(0, 9) == 0);
      redirect_ex = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0; hold = 0; redirect_ex = 0; valid_id = 0;
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
